// File: rtl/hams_block_packer_pkg.sv
// Shared types and defaults for the bitonic sorter front end.
package hams_block_packer_pkg;

  typedef logic [31:0] pair;

  localparam int unsigned NUM_ELEMENTS = 8;
  localparam pair         PAD_INFO     = 32'hFFFF_FFFF;
  localparam int unsigned CNT_W        = $clog2(NUM_ELEMENTS) + 1;

endpackage

// File: rtl/hams_pack_bank.sv
// One packing bank: slot storage, seal-with-pad, and full/count/last flags.
module hams_pack_bank
  import hams_block_packer_pkg::*;
#(
  parameter int unsigned N   = NUM_ELEMENTS,
  parameter pair         PAD = PAD_INFO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [$clog2(N)-1:0]  wr_idx_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  seal_i,
  input  logic                  last_i,
  input  logic                  clr_i,
  output logic [N-1:0][31:0]    slots_o,
  output logic                  full_o,
  output logic [$clog2(N):0]    count_o,
  output logic                  last_o
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = IW + 1;

  logic [N-1:0][31:0] slots_q;
  logic               full_q;
  logic [CW-1:0]      count_q;
  logic               last_q;

  // Release and seal never target the same bank in one cycle (seal needs !full).
  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q <= '0;
      full_q  <= 1'b0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      if (clr_i) full_q <= 1'b0;
      if (wr_en_i) begin
        slots_q[wr_idx_i] <= wr_data_i;
        if (seal_i) begin
          for (int unsigned k = 0; k < N; k++) begin
            if (k > 32'(wr_idx_i)) slots_q[k[IW-1:0]] <= PAD;
          end
          count_q <= {1'b0, wr_idx_i} + CW'(1);
          last_q  <= last_i;
          full_q  <= 1'b1;
        end
      end
    end
  end

  assign slots_o = slots_q;
  assign full_o  = full_q;
  assign count_o = count_q;
  assign last_o  = last_q;

endmodule

// File: rtl/hams_block_packer.sv
// Gathers a serial pair stream into padded NUM_ELEMENTS blocks over two ping-pong banks.
module hams_block_packer
  import hams_block_packer_pkg::*;
#(
  parameter int unsigned NUM_ELEMENTS = hams_block_packer_pkg::NUM_ELEMENTS,
  parameter logic [31:0] PAD_VALUE    = PAD_INFO
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [31:0]                    in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_ELEMENTS*32-1:0]     out_data,
  output logic [$clog2(NUM_ELEMENTS):0]  out_count,
  output logic                           out_last
);

  localparam int unsigned IW = $clog2(NUM_ELEMENTS);
  localparam int unsigned CW = IW + 1;

  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          accept, seal, rel;

  logic [1:0]                     bank_full;
  logic [1:0]                     bank_last;
  logic [NUM_ELEMENTS-1:0][31:0]  bank_slots [2];
  logic [CW-1:0]                  bank_count [2];

  // in_ready depends on registered state only, never on out_ready.
  assign in_ready  = ~bank_full[wb_q];
  assign accept    = in_valid & in_ready;
  assign seal      = accept & ((idx_q == IW'(NUM_ELEMENTS - 1)) | in_last);
  assign out_valid = bank_full[rb_q];
  assign rel       = out_valid & out_ready;
  assign out_data  = bank_slots[rb_q];
  assign out_count = bank_count[rb_q];
  assign out_last  = bank_last[rb_q];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    hams_pack_bank #(
      .N   (NUM_ELEMENTS),
      .PAD (PAD_VALUE)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (accept && (wb_q == 1'(b))),
      .wr_idx_i  (idx_q),
      .wr_data_i (in_data),
      .seal_i    (seal),
      .last_i    (in_last),
      .clr_i     (rel && (rb_q == 1'(b))),
      .slots_o   (bank_slots[b]),
      .full_o    (bank_full[b]),
      .count_o   (bank_count[b]),
      .last_o    (bank_last[b])
    );
  end

  always_comb begin
    wb_d  = wb_q;
    rb_d  = rb_q;
    idx_d = idx_q;
    if (seal) begin
      idx_d = '0;
      wb_d  = ~wb_q;
    end else if (accept) begin
      idx_d = idx_q + 1'b1;
    end
    if (rel) rb_d = ~rb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q  <= 1'b0;
      rb_q  <= 1'b0;
      idx_q <= '0;
    end else begin
      wb_q  <= wb_d;
      rb_q  <= rb_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: tb/tb_hams_block_packer.sv
// Self-checking bench for hams_block_packer: vector table, directed corners, random vs. queue model.
module tb_hams_block_packer;

  localparam int unsigned NE  = 8;
  localparam int unsigned CW  = $clog2(NE) + 1;
  localparam int unsigned DW  = NE * 32;
  localparam logic [31:0] PAD = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_last;
  logic          out_valid, out_ready, out_last;
  logic [31:0]   in_data;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_count;

  always #5 clk = ~clk;

  hams_block_packer #(
    .NUM_ELEMENTS (NE),
    .PAD_VALUE    (PAD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_last  (out_last)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic          v;
    logic [31:0]   d;
    logic          l;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic [CW-1:0] e_cnt;
    logic          e_last;
    logic [DW-1:0] e_data;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          l;
  } blk_t;

  vec_t        tbl[$];
  blk_t        mq[$];
  logic [31:0] cur[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // slot k = base+k for k<n, PAD above
  function automatic logic [DW-1:0] seqblk(input logic [31:0] base, input int n);
    logic [DW-1:0] r;
    for (int k = 0; k < NE; k++) r[k*32 +: 32] = (k < n) ? base + 32'(k) : PAD;
    return r;
  endfunction

  function automatic void add(input logic v, input logic [31:0] d, input logic l,
                              input logic ir, input logic ov, input logic [CW-1:0] c,
                              input logic lst, input logic [DW-1:0] dat);
    vec_t e;
    e.v = v; e.d = d; e.l = l; e.ordy = 1'b1;
    e.e_ir = ir; e.e_ov = ov; e.e_cnt = c; e.e_last = lst; e.e_data = dat;
    tbl.push_back(e);
  endfunction

  initial begin
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);

    // Reset state
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);

    // Vector table (out_ready held high)
    for (int i = 0; i < 7; i++) add(1, 32'(8 - i), 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 8, 0, {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8});
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 5, 0, 1, 0, 0, 0, 0);
    add(1, 9, 0, 1, 0, 0, 0, 0);
    add(1, 2, 1, 1, 1, 3, 1, {{5{PAD}}, 32'd2, 32'd9, 32'd5});
    add(0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) add(1, 32'h100 + 32'(i), 0, 1, 0, 0, 0, 0);
    add(1, 32'h107, 1, 1, 1, 8, 1, seqblk(32'h100, 8));
    add(0, 0, 0, 1, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy);
      step();
      check("tbl_in_ready", in_ready, tbl[i].e_ir);
      check("tbl_out_valid", out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        check("tbl_out_count", out_count, tbl[i].e_cnt);
        check("tbl_out_last", out_last, tbl[i].e_last);
        check("tbl_out_data", out_data, tbl[i].e_data);
      end
    end

    // Back-pressure: 16 absorbed, 17th stalls until a bank frees
    do_reset();
    for (int i = 0; i < 17; i++) begin
      check("bp_in_ready", in_ready, (i < 16));
      drive(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
      if (i < 16) step();
    end
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, seqblk(32'h200, 8));
      check("bp_hold_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    check("bp_no_comb_ready", in_ready, 0);
    check("bp_blk1_data", out_data, seqblk(32'h200, 8));
    step();
    check("bp_freed_ready", in_ready, 1);
    check("bp_blk2_valid", out_valid, 1);
    check("bp_blk2_data", out_data, seqblk(32'h208, 8));
    check("bp_blk2_count", out_count, 8);
    step();
    drive(1'b0, '0, 1'b0, 1'b1);
    check("bp_drained", out_valid, 0);
    drive(1'b1, 32'h211, 1'b1, 1'b1);
    step();
    drive(1'b0, '0, 1'b0, 1'b1);
    check("bp_blk3_valid", out_valid, 1);
    check("bp_blk3_data", out_data, seqblk(32'h210, 2));
    check("bp_blk3_count", out_count, 2);
    check("bp_blk3_last", out_last, 1);
    step();
    check("bp_end_valid", out_valid, 0);

    // Back-to-back single-element blocks
    do_reset();
    for (int i = 0; i < 6; i++) begin
      check("single_in_ready", in_ready, 1);
      drive(1'b1, 32'h300 + 32'(i), 1'b1, 1'b1);
      step();
      check("single_valid", out_valid, 1);
      check("single_count", out_count, 1);
      check("single_last", out_last, 1);
      check("single_data", out_data, seqblk(32'h300 + 32'(i), 1));
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    check("single_end_valid", out_valid, 0);

    // Reset mid-fill
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h400 + 32'(i), 1'b0, 1'b1);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ready", in_ready, 1);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_count", out_count, 0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h500 + 32'(i), 1'b0, 1'b1);
      step();
      if (i < 7) check("mid_rst_nodata", out_valid, 0);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    check("mid_rst_blk_valid", out_valid, 1);
    check("mid_rst_blk_count", out_count, 8);
    check("mid_rst_blk_data", out_data, seqblk(32'h500, 8));
    check("mid_rst_blk_last", out_last, 0);
    step();

    // Randomized run against a queue-of-blocks model
    do_reset();
    mq.delete();
    cur.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic acc, rel;
      blk_t nb;
      drive(($urandom_range(0, 3) != 0), $urandom(), ($urandom_range(0, 4) == 0),
            (cyc < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      check("rnd_in_ready", in_ready, (mq.size() < 2));
      check("rnd_out_valid", out_valid, (mq.size() != 0));
      if (mq.size() != 0) begin
        check("rnd_out_data", out_data, mq[0].d);
        check("rnd_out_count", out_count, mq[0].c);
        check("rnd_out_last", out_last, mq[0].l);
      end
      acc = in_valid && (mq.size() < 2);
      rel = (mq.size() != 0) && out_ready;
      if (rel) void'(mq.pop_front());
      if (acc) begin
        cur.push_back(in_data);
        if (cur.size() == NE || in_last) begin
          for (int k = 0; k < NE; k++) nb.d[k*32 +: 32] = (k < cur.size()) ? cur[k] : PAD;
          nb.c = CW'(cur.size());
          nb.l = in_last;
          mq.push_back(nb);
          cur.delete();
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
